// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the CPU and a
// display-scan reader. The CPU always wins; scan reads are slipped into cycles where
// the CPU is not touching memory.
//
// Ports:
//   clock, reset          - system clock; asynchronous active-low reset
//   cpu_mem_active        - CPU load/store in progress this cycle
//   cpu_wren              - CPU store strobe (qualified by cpu_mem_active)
//   cpu_addr, cpu_wdata   - CPU word address and store data
//   cpu_rdata             - CPU load data (straight from the RAM output)
//   scan_req, scan_addr   - scan read request, held until scan_ack
//   scan_ack              - pulse in the cycle the scan read is issued to RAM
//   scan_rvalid           - scan read data valid (cycle after scan_ack)
//   scan_rdata            - scan read data, held until the next returned word
//   scan_starve           - scan request has waited at least STARVE_LIMIT cycles
//   ram_wEn, ram_addr,
//   ram_dataIn            - RAM write enable, address and write data
//   ram_dataOut           - RAM read data, one cycle after the address
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned STARVE_LIMIT  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_mem_active,
    input  logic                     cpu_wren,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    input  logic                     scan_req,
    input  logic [ADDRESS_WIDTH-1:0] scan_addr,
    output logic                     scan_ack,
    output logic                     scan_rvalid,
    output logic [DATA_WIDTH-1:0]    scan_rdata,
    output logic                     scan_starve,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic                    starve_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    issue;

    // Both states accept a new issue, so a scan read only needs an idle CPU. Gating
    // with reset keeps the RAM and handshake quiet while the block is held in reset.
    assign issue = reset & scan_req & ~cpu_mem_active;

    // State register and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
            starve_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            // Compare against the next count so the flag always matches the counter.
            starve_q   <= (32'(wait_cnt_d) >= STARVE_LIMIT);
            if (state_q == StResp) begin
                rdata_q <= ram_dataOut;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = issue ? StResp : StIdle;
            StResp:  state_d = issue ? StResp : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Wait counter: counts blocked request cycles, saturating; a dropped or granted
    // request clears it, so nothing of an abandoned request survives.
    always_comb begin
        wait_cnt_d = 8'd0;
        if (scan_req && !issue) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
    end

    // Outputs.
    always_comb begin
        scan_ack    = issue;
        scan_rvalid = (state_q == StResp);
        // The RAM word is live in the response cycle; afterwards the captured copy holds.
        scan_rdata  = scan_rvalid ? ram_dataOut : rdata_q;
        scan_starve = starve_q;
        cpu_rdata   = ram_dataOut;
        ram_wEn     = reset & cpu_mem_active & cpu_wren;
        ram_addr    = issue ? scan_addr : cpu_addr;
        ram_dataIn  = cpu_wdata;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic,
// compared against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 12;
    localparam int unsigned SL = 16;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_mem_active = 1'b0;
    logic          cpu_wren = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          scan_req = 1'b0;
    logic [AW-1:0] scan_addr = '0;
    logic          scan_ack;
    logic          scan_rvalid;
    logic [DW-1:0] scan_rdata;
    logic          scan_starve;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn;
    logic [DW-1:0] ram_dataOut;

    dmem_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_mem_active(cpu_mem_active),
        .cpu_wren      (cpu_wren),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .scan_req      (scan_req),
        .scan_addr     (scan_addr),
        .scan_ack      (scan_ack),
        .scan_rvalid   (scan_rvalid),
        .scan_rdata    (scan_rdata),
        .scan_starve   (scan_starve),
        .ram_wEn       (ram_wEn),
        .ram_addr      (ram_addr),
        .ram_dataIn    (ram_dataIn),
        .ram_dataOut   (ram_dataOut)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM driven by the DUT.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_dout;
    always @(posedge clock) begin
        if (ram_wEn) ram[ram_addr] <= ram_dataIn;
        ram_dout <= ram[ram_addr];
    end
    assign ram_dataOut = ram_dout;

    // Reference model: memory contents as the CPU sees them, plus expected scan state.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_rvalid;
    logic [DW-1:0] m_rdata;
    int unsigned   m_wait;
    bit            m_starve;
    bit            seen_ack;
    bit            exp_ack;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit act, input bit wren, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input bit req, input logic [AW-1:0] sa);
        cpu_mem_active = act;
        cpu_wren       = wren;
        cpu_addr       = a;
        cpu_wdata      = wd;
        scan_req       = req;
        scan_addr      = sa;
    endtask

    // One clock cycle: check all outputs against the model, then advance the model.
    task automatic cycle();
        bit iss;
        if (!reset) begin
            m_rvalid = 0; m_rdata = '0; m_wait = 0; m_starve = 0;
        end
        #1;
        exp_ack  = reset && scan_req && !cpu_mem_active;
        seen_ack = scan_ack;
        check("scan_ack", 64'(scan_ack), 64'(exp_ack));
        check("ram_addr", 64'(ram_addr), exp_ack ? 64'(scan_addr) : 64'(cpu_addr));
        check("ram_wEn", 64'(ram_wEn), 64'(reset && cpu_mem_active && cpu_wren));
        if (cpu_mem_active) check("ram_dataIn", 64'(ram_dataIn), 64'(cpu_wdata));
        check("cpu_rdata", 64'(cpu_rdata), 64'(ram_dout));
        check("scan_rvalid", 64'(scan_rvalid), 64'(m_rvalid));
        check("scan_rdata", 64'(scan_rdata), 64'(m_rdata));
        check("scan_starve", 64'(scan_starve), 64'(m_starve));
        @(posedge clock);
        if (!reset) begin
            m_rvalid = 0; m_rdata = '0; m_wait = 0; m_starve = 0;
        end else begin
            iss = scan_req && !cpu_mem_active;
            m_rvalid = iss;
            if (iss) m_rdata = ref_mem[scan_addr];
            m_wait = (scan_req && !iss) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
            m_starve = (m_wait >= SL);
            if (cpu_mem_active && cpu_wren) ref_mem[cpu_addr] = cpu_wdata;
        end
        @(negedge clock);
    endtask

    initial begin
        logic [DW-1:0] v;
        bit            req_on;
        logic [AW-1:0] sa;
        int            p;
        int            acks;

        for (int i = 0; i < int'(DEPTH); i++) begin
            v = $urandom;
            ram[i] <= v;
            ref_mem[i] = v;
        end
        ram[12'h010] <= 32'hCAFE0001;
        ref_mem[12'h010] = 32'hCAFE0001;

        // Reset: outputs quiet and no write even with a CPU store pending.
        drive(1, 1, 12'h005, 32'hDEADBEEF, 1, 12'h010);
        @(negedge clock);
        cycle();
        check("rst_wEn", 64'(ram_wEn), 64'd0);
        check("rst_ack", 64'(scan_ack), 64'd0);
        cycle();
        reset = 1'b1;

        // Basic scan read of a preloaded word.
        drive(0, 0, 12'h000, 32'h0, 1, 12'h010);
        cycle();
        check("basic_ack", 64'(seen_ack), 64'd1);
        check("basic_rvalid", 64'(scan_rvalid), 64'd1);
        check("basic_rdata", 64'(scan_rdata), 64'hCAFE0001);
        drive(0, 0, 12'h000, 32'h0, 0, 12'h000);
        cycle();
        check("basic_hold", 64'(scan_rdata), 64'hCAFE0001);

        // CPU store and scan read to the same address: store first, scan sees new data.
        drive(1, 1, 12'h010, 32'h12345678, 1, 12'h010);
        cycle();
        check("coll_noack", 64'(seen_ack), 64'd0);
        drive(0, 0, 12'h000, 32'h0, 1, 12'h010);
        cycle();
        check("coll_ack", 64'(seen_ack), 64'd1);
        check("coll_rdata", 64'(scan_rdata), 64'h12345678);
        drive(0, 0, 12'h000, 32'h0, 0, 12'h000);
        cycle();

        // Starvation: CPU busy long enough to also exercise counter saturation.
        for (int k = 1; k <= 300; k++) begin
            drive(1, 0, AW'($urandom), 32'h0, 1, 12'h020);
            cycle();
            if (k == 15) check("starve_15", 64'(scan_starve), 64'd0);
            if (k == 16) check("starve_16", 64'(scan_starve), 64'd1);
            if (k == 20) check("starve_noack", 64'(seen_ack), 64'd0);
        end
        check("starve_sat", 64'(scan_starve), 64'd1);
        drive(0, 0, 12'h000, 32'h0, 1, 12'h020);
        cycle();
        check("starve_ack", 64'(seen_ack), 64'd1);

        // Back-to-back scan of addresses 0..7.
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 12'h000, 32'h0, 1, AW'(i));
            cycle();
            acks += int'(seen_ack);
            check("b2b_rvalid", 64'(scan_rvalid), 64'd1);
            check("b2b_rdata", 64'(scan_rdata), 64'(ref_mem[i]));
        end
        check("b2b_acks", 64'(acks), 64'd8);
        drive(0, 0, 12'h000, 32'h0, 0, 12'h000);
        cycle();

        // Reset right after an issue: the pending response must vanish.
        drive(0, 0, 12'h000, 32'h0, 1, 12'h030);
        cycle();
        reset = 1'b0;
        cycle();
        check("rst_rvalid", 64'(scan_rvalid), 64'd0);
        check("rst_rdata", 64'(scan_rdata), 64'd0);
        cycle();
        reset = 1'b1;
        drive(0, 0, 12'h000, 32'h0, 0, 12'h000);
        cycle();
        check("rst_release", 64'(scan_rvalid), 64'd0);

        // Request dropped after three wait cycles: no late read.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 12'h100, 32'h0, 1, 12'h040);
            cycle();
        end
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 12'h000, 32'h0, 0, 12'h040);
            cycle();
            acks += int'(seen_ack) + int'(scan_rvalid);
        end
        check("drop_none", 64'(acks), 64'd0);

        // Randomized traffic with varying CPU load, drops and occasional resets.
        req_on = 0;
        sa = '0;
        p = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) p = (n / 200) % 3 == 0 ? 10 : ((n / 200) % 3 == 1 ? 50 : 97);
            if (!req_on) begin
                req_on = ($urandom_range(0, 2) != 0);
                sa = AW'($urandom_range(0, 31));
            end else if ($urandom_range(0, 29) == 0) begin
                req_on = 0;
            end
            drive($urandom_range(0, 99) < p, $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 31)), $urandom, req_on, sa);
            if ($urandom_range(0, 599) == 0) reset = 1'b0;
            else reset = 1'b1;
            cycle();
            if (exp_ack) req_on = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 12, RAM word-address width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 16, scan wait cycles before the starve flag asserts (range 1..255).
REQ-004 The block SHALL have port clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port cpu_mem_active, input, 1, the CPU is executing a load or store this cycle.
REQ-007 The block SHALL have port cpu_wren, input, 1, the CPU store strobe, qualified by cpu_mem_active.
REQ-008 The block SHALL have ports cpu_addr (input, ADDRESS_WIDTH) and cpu_wdata (input, DATA_WIDTH), the CPU address and store data.
REQ-009 The block SHALL have port cpu_rdata, output, DATA_WIDTH, equal to ram_dataOut at all times.
REQ-010 The block SHALL have ports scan_req (input, 1) and scan_addr (input, ADDRESS_WIDTH), the display-scan read request; both are held stable until scan_ack.
REQ-011 The block SHALL have port scan_ack, output, 1, a one-cycle pulse marking the cycle the scan read is issued to RAM.
REQ-012 The block SHALL have ports scan_rvalid (output, 1) and scan_rdata (output, DATA_WIDTH), the returned scan read data.
REQ-013 The block SHALL have port scan_starve, output, 1, the scan request has waited at least STARVE_LIMIT cycles.
REQ-014 The block SHALL have ports ram_wEn (output, 1), ram_addr (output, ADDRESS_WIDTH), ram_dataIn (output, DATA_WIDTH) and ram_dataOut (input, DATA_WIDTH), the single-port synchronous RAM; read data appears one cycle after the address.

Function
REQ-015 The CPU SHALL have absolute priority: when cpu_mem_active=1, ram_addr=cpu_addr, ram_wEn=cpu_wren and ram_dataIn=cpu_wdata in the same cycle, combinationally.
REQ-016 When cpu_mem_active=0, ram_addr SHALL equal cpu_addr and ram_wEn SHALL be 0, unless a scan read is issued.
REQ-017 A scan read SHALL be issued in any cycle where scan_req=1, cpu_mem_active=0 and state is IDLE or RESP: ram_addr=scan_addr, ram_wEn=0 and scan_ack=1 in that cycle.
REQ-018 The state machine SHALL have states IDLE and RESP; an issue moves it to RESP; RESP with no issue returns it to IDLE.
REQ-019 In the cycle after an issue, scan_rvalid SHALL be 1 and scan_rdata SHALL register ram_dataOut, holding that value until the next capture.
REQ-020 Back-to-back issues SHALL be allowed, giving one scan word per idle cycle at full throughput.
REQ-021 A CPU store and a pending scan read to the same address in the same cycle SHALL serve the store first; the later scan read returns the new data.
REQ-022 wait_cnt (8-bit, internal) SHALL increment, saturating at 255, each cycle scan_req=1 and scan_ack=0, and SHALL clear on scan_ack or when scan_req=0.
REQ-023 scan_starve SHALL be registered and equal (wait_cnt >= STARVE_LIMIT); it SHALL not alter priority.
REQ-024 When scan_req deasserts without an ack, the block SHALL discard the request and SHALL NOT issue a late read.

Reset
REQ-025 While reset=0, state SHALL be IDLE, wait_cnt=0, scan_rvalid=0, scan_ack=0, scan_starve=0 and scan_rdata=0, asynchronously.
REQ-026 A read issued in the cycle before reset asserts SHALL produce no scan_rvalid after reset releases.
REQ-027 ram_wEn SHALL be 0 while reset=0, regardless of cpu_wren.

Verification
REQ-028 Idle CPU, scan_req=1, scan_addr=0x010, RAM[0x010]=0xCAFE0001 -> scan_ack=1 in cycle N; scan_rvalid=1 and scan_rdata=0xCAFE0001 in cycle N+1.
REQ-029 cpu_mem_active=1 with cpu_wren=1, cpu_addr=0x010, cpu_wdata=0x12345678, and scan_req=1 to 0x010 in the same cycle -> store performed, no ack; next idle cycle ack; returned data=0x12345678.
REQ-030 cpu_mem_active=1 for 20 cycles with scan_req=1 and STARVE_LIMIT=16 -> scan_starve rises after the 16th wait cycle; no ack; ram_addr tracks cpu_addr throughout.
REQ-031 Scan to addresses 0..7 with the CPU idle -> eight consecutive acks and eight consecutive rvalids with the correct words, and zero bubbles.
REQ-032 Ack issued, then reset pulled low for 2 cycles -> all outputs 0 during reset; no scan_rvalid after release.
REQ-033 scan_req dropped after 3 wait cycles -> wait_cnt cleared; no ack or rvalid follows.
